sync_fifo_flags: RTL
====================

// Module: sync_fifo_flags
// PURPOSE
//   Parametrised single-clock FIFO, the successor to the basic 8x16 FIFO.
//   Adds selectable read mode (registered or first-word-fall-through), an occupancy count,
//   programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//   Sits between producer/consumer blocks in one clock domain.
// PARAMETERS
//   DATA_WIDTH  8   width of din/dout
//   DEPTH       16  number of entries; power of two, >= 2
//   AF_THRESH   12  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH   4   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//   FWFT        0   0: registered read; 1: first-word-fall-through
//   CW = $clog2(DEPTH)+1 (localparam, count width)
// PORTS
//   clk           in   1           clock, rising edge
//   rst           in   1           synchronous reset, active-high
//   wr_en         in   1           write request
//   din           in   DATA_WIDTH  write data
//   rd_en         in   1           read request (pop)
//   dout          out  DATA_WIDTH  read data
//   full          out  1           count == DEPTH
//   empty         out  1           count == 0
//   almost_full   out  1           count >= AF_THRESH
//   almost_empty  out  1           count <= AE_THRESH
//   count         out  CW          current occupancy, 0..DEPTH
//   overflow      out  1           sticky: write rejected since last clear
//   underflow     out  1           sticky: read rejected since last clear
//   clr_err       in   1           clears overflow/underflow next edge
// BEHAVIOUR
//   - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1,
//     almost_full=0, dout=0, overflow=underflow=0; memory contents not cleared. Reset wins over all
//     other inputs in that cycle, including mid-burst.
//   - rd_acc = rd_en & ~empty; wr_acc = wr_en & (~full | rd_acc).
//   - Full + wr_en + rd_en: both accepted, count unchanged (read frees the slot same cycle).
//   - Empty + wr_en + rd_en: write accepted, read rejected, underflow set, count -> 1.
//   - count next = count + wr_acc - rd_acc; all flags are registered from next count (no comb path
//     from inputs to flags).
//   - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//   - FWFT=0: on rd_acc, dout <= mem[rd_ptr] at that edge (1-cycle latency); otherwise dout holds.
//   - FWFT=1: dout = mem[rd_ptr] continuously while ~empty (0 latency); rd_en pops; when
//     empty, dout holds last value; a write to empty FIFO is visible on dout next cycle.
//   - overflow set when wr_en & ~wr_acc; underflow set when rd_en & ~rd_acc; stay set until
//     clr_err or rst. Set and clr_err in same cycle: set wins.
//   - Rejected operations change no pointer, count or memory.
// TESTING
//   1 Reset: rst=1 2 cycles -> count=0, empty=1, almost_empty=1, full=0, almost_full=0, errors=0.
//   2 Fill: write 1..20 (FWFT=0) -> almost_full at 12th write, full after 16th, overflow=1,
//     count=16; read 16 -> dout 1..16 in order, each 1 cycle after rd_en; empty after 16th.
//   3 Underflow: read empty FIFO -> underflow=1, count=0; clr_err pulse -> underflow=0.
//   4 Simultaneous: full + wr_en&rd_en -> count stays 16, oldest popped, new data at tail;
//     empty + wr_en&rd_en -> count=1, underflow=1.
//   5 FWFT=1: write 0xA5 to empty -> dout=0xA5 next cycle with rd_en=0; pop -> empty=1.
//   6 Mid-op reset: random concurrent R/W, rst asserted at arbitrary cycle -> next cycle
//     count=0, empty=1, wr_ptr=rd_ptr=0; scoreboard flushed, subsequent traffic in order.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and selectable registered or FWFT read.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [CW-1:0]         count_next;
  logic                  rd_acc;
  logic                  wr_acc;

  // A read on a full FIFO frees the slot the concurrent write lands in.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    count_next = count + CW'(wr_acc) - CW'(rd_acc);
  end

  // Storage is deliberately not reset; a write coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      dout_q       <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout_q <= mem[rd_ptr];
      end
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == CW'(DEPTH));
      almost_full  <= (count_next >= CW'(AF_THRESH));
      almost_empty <= (count_next <= CW'(AE_THRESH));
      overflow     <= (wr_en & ~wr_acc) | (overflow & ~clr_err);
      underflow    <= (rd_en & ~rd_acc) | (underflow & ~clr_err);
    end
  end

  // In FWFT mode dout_q holds the last popped word, shown once the FIFO runs empty.
  generate
    if (FWFT != 0) begin : g_fwft
      assign dout = empty ? dout_q : mem[rd_ptr];
    end else begin : g_reg
      assign dout = dout_q;
    end
  endgenerate

endmodule
